ps2_scancode_rx: RTL and testbench

PS/2 device-to-host receiver that turns the raw ps2_clock/ps2_data pin pair into validated 8-bit scancode bytes, each qualified by a single-cycle valid pulse. It sits directly upstream of the keyboard command decoder that maps scancodes to pause/start/clear/file-select. It adds glitch filtering, frame checking, a mid-frame timeout and break/extended prefix tracking.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_scancode_rx_if.sv | 24 ++
 rtl/ps2_line_filter.sv | 54 +++++
 rtl/ps2_scancode_rx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, prefix bytes and the scancodes
// the downstream keyboard command decoder acts on.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Set-2 make codes used by the command decoder (digits select files)
  localparam logic [7:0] KEY_0     = 8'h45;
  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_6     = 8'h36;
  localparam logic [7:0] KEY_7     = 8'h3D;
  localparam logic [7:0] KEY_8     = 8'h3E;
  localparam logic [7:0] KEY_9     = 8'h46;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_R     = 8'h2D;

  // PS/2 uses odd parity over the data byte plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  function automatic logic is_prefix(input logic [7:0] data);
    return (data == PS2_BREAK) || (data == PS2_EXT);
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Scancode output bus from the PS/2 receiver to the command decoder.
interface ps2_scancode_rx_if;
  logic [7:0] scancode;
  logic       valid;
  logic       is_break;
  logic       is_ext;
  logic       frame_err;

  modport master (
    output scancode,
    output valid,
    output is_break,
    output is_ext,
    output frame_err
  );

  modport slave (
    input scancode,
    input valid,
    input is_break,
    input is_ext,
    input frame_err
  );
endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus stability filter for the PS/2 clock pin; emits a
// one-cycle pulse in the first cycle the filtered level reads low.
module ps2_line_filter #(
  parameter int   FILTER_CYCLES = 8,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic pin,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          fall_reg;
  logic          sync_level;

  assign sync_level = sync_reg[1];
  assign fall       = fall_reg;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_reg <= {2{RESET_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[0], pin};
    end
  end

  // The level only flips after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      level_reg <= RESET_LEVEL;
      cnt_reg   <= '0;
      fall_reg  <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (sync_level != level_reg) begin
        if (cnt_reg == CW'(FILTER_CYCLES - 1)) begin
          level_reg <= sync_level;
          cnt_reg   <= '0;
          fall_reg  <= level_reg & ~sync_level;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver: filtered clock, 11-bit frame check,
// mid-frame timeout and break/extended prefix tracking.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PASS_PREFIX    = 1
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      ps2_clock,
  input  logic                      ps2_data,
  ps2_scancode_rx_if.master         rx_bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic          fall;
  logic [1:0]    data_sync_reg;
  logic          data_sync;
  logic          timeout_hit;

  rx_state_t     state_reg,      state_next;
  logic [2:0]    bit_cnt_reg,    bit_cnt_next;
  logic [7:0]    shift_reg,      shift_next;
  logic          parity_reg,     parity_next;
  logic [TW-1:0] timeout_reg,    timeout_next;
  logic          break_pend_reg, break_pend_next;
  logic          ext_pend_reg,   ext_pend_next;
  logic [7:0]    scancode_reg,   scancode_next;
  logic          valid_reg,      valid_next;
  logic          is_break_reg,   is_break_next;
  logic          is_ext_reg,     is_ext_next;
  logic          frame_err_reg,  frame_err_next;

  ps2_line_filter #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_LEVEL   (1'b1)
  ) u_clk_filter (
    .clk_in (clk_in),
    .reset  (reset),
    .pin    (ps2_clock),
    .fall   (fall)
  );

  // Data is stable for many microseconds around a clock edge, so it needs
  // no filtering, only synchronizing.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      data_sync_reg <= 2'b11;
    end else begin
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  assign data_sync   = data_sync_reg[1];
  assign timeout_hit = (timeout_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      timeout_reg    <= '0;
      break_pend_reg <= 1'b0;
      ext_pend_reg   <= 1'b0;
      scancode_reg   <= '0;
      valid_reg      <= 1'b0;
      is_break_reg   <= 1'b0;
      is_ext_reg     <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      timeout_reg    <= timeout_next;
      break_pend_reg <= break_pend_next;
      ext_pend_reg   <= ext_pend_next;
      scancode_reg   <= scancode_next;
      valid_reg      <= valid_next;
      is_break_reg   <= is_break_next;
      is_ext_reg     <= is_ext_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_next     = parity_reg;
    timeout_next    = timeout_reg + TW'(1);
    break_pend_next = break_pend_reg;
    ext_pend_next   = ext_pend_reg;
    scancode_next   = scancode_reg;
    is_break_next   = is_break_reg;
    is_ext_next     = is_ext_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (fall) begin
          if (!data_sync) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end

      DATA: begin
        if (fall) begin
          shift_next   = {data_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end else if (timeout_hit) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end

      PARITY: begin
        if (fall) begin
          parity_next = data_sync;
          state_next  = STOP;
        end else if (timeout_hit) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end

      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (data_sync && odd_parity_ok(shift_reg, parity_reg)) begin
            if (shift_reg == PS2_BREAK) begin
              break_pend_next = 1'b1;
              if (PASS_PREFIX != 0) begin
                scancode_next = shift_reg;
                valid_next    = 1'b1;
                is_break_next = 1'b0;
                is_ext_next   = ext_pend_reg;
              end
            end else if (shift_reg == PS2_EXT) begin
              ext_pend_next = 1'b1;
              if (PASS_PREFIX != 0) begin
                scancode_next = shift_reg;
                valid_next    = 1'b1;
                is_break_next = 1'b0;
                is_ext_next   = 1'b0;
              end
            end else begin
              scancode_next   = shift_reg;
              valid_next      = 1'b1;
              is_break_next   = break_pend_reg;
              is_ext_next     = ext_pend_reg;
              break_pend_next = 1'b0;
              ext_pend_next   = 1'b0;
            end
          end else begin
            frame_err_next = 1'b1;
          end
        end else if (timeout_hit) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A fall event restarts the inter-edge timer; leaving the frame parks it
    if (fall || state_next == IDLE) begin
      timeout_next = '0;
    end
  end

  assign rx_bus.scancode  = scancode_reg;
  assign rx_bus.valid     = valid_reg;
  assign rx_bus.is_break  = is_break_reg;
  assign rx_bus.is_ext    = is_ext_reg;
  assign rx_bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: two instances (prefixes passed / consumed)
// checked every cycle against a byte-level model of the PS/2 receive rules.
module tb_ps2_scancode_rx;

  localparam int FILT = 8;
  localparam int TO   = 1000;
  localparam int H    = 20;

  logic clk_in    = 1'b0;
  logic reset     = 1'b1;
  logic ps2_clock = 1'b1;
  logic ps2_data  = 1'b1;

  always #5 clk_in = ~clk_in;

  ps2_scancode_rx_if bus_a ();
  ps2_scancode_rx_if bus_b ();

  ps2_scancode_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TO), .PASS_PREFIX(1)) dut_a (
    .clk_in    (clk_in),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .rx_bus    (bus_a)
  );

  ps2_scancode_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TO), .PASS_PREFIX(0)) dut_b (
    .clk_in    (clk_in),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .rx_bus    (bus_b)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic       brk_pend [2];
  logic       ext_pend [2];
  int         n_valid  [2];
  int         n_err    [2];
  int         err_cyc  [2];
  logic       prev_v   [2];
  logic       prev_fe  [2];
  logic       prev_b   [2];
  logic       prev_e   [2];
  logic [7:0] prev_sc  [2];

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int last_fall_cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic note(input string name, input int id, input bit ok, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s dut%0d: got %0h, expected %0h", name, id, act, exp);
  endtask

  function automatic void push_exp(input int id, input exp_t e);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic bit pop_exp(input int id, output exp_t e);
    e = '{1'b0, 8'h00, 1'b0, 1'b0};
    if (id == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic void model_err();
    push_exp(0, '{1'b1, 8'h00, 1'b0, 1'b0});
    push_exp(1, '{1'b1, 8'h00, 1'b0, 1'b0});
  endfunction

  // Byte-level rules: prefixes arm a flag, a normal byte consumes both flags
  function automatic void model_good(input int id, input bit pass, input logic [7:0] b);
    if (b == 8'hF0) begin
      if (pass) push_exp(id, '{1'b0, b, 1'b0, ext_pend[id]});
      brk_pend[id] = 1'b1;
    end else if (b == 8'hE0) begin
      if (pass) push_exp(id, '{1'b0, b, 1'b0, 1'b0});
      ext_pend[id] = 1'b1;
    end else begin
      push_exp(id, '{1'b0, b, brk_pend[id], ext_pend[id]});
      brk_pend[id] = 1'b0;
      ext_pend[id] = 1'b0;
    end
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic p, input logic s);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    ones += int'(p);
    if ((ones % 2) == 1 && s) begin
      model_good(0, 1'b1, b);
      model_good(1, 1'b0, b);
    end else begin
      model_err();
    end
  endfunction

  task automatic check_out(input int id, input logic v, input logic fe, input logic [7:0] sc,
                           input logic b, input logic e);
    exp_t x;
    bit   ok;
    if (v && fe) note("valid_with_err", id, 1'b0, 3, 0);
    if (v) begin
      n_valid[id]++;
      ok = pop_exp(id, x);
      note("valid_byte", id, ok && !x.is_err && x.code == sc && x.brk == b && x.ext == e,
           int'({sc, b, e}), ok ? int'({x.code, x.brk, x.ext}) : -1);
      note("valid_width", id, !prev_v[id], int'(prev_v[id]), 0);
    end else begin
      note("hold", id, sc == prev_sc[id] && b == prev_b[id] && e == prev_e[id],
           int'({sc, b, e}), int'({prev_sc[id], prev_b[id], prev_e[id]}));
    end
    if (fe) begin
      n_err[id]++;
      err_cyc[id] = cyc;
      ok = pop_exp(id, x);
      note("frame_err", id, ok && x.is_err, 1, ok ? int'({x.code, x.brk, x.ext}) : -1);
      note("err_width", id, !prev_fe[id], int'(prev_fe[id]), 0);
    end
    prev_v[id]  = v;
    prev_fe[id] = fe;
    prev_sc[id] = sc;
    prev_b[id]  = b;
    prev_e[id]  = e;
  endtask

  always @(negedge clk_in) begin
    if (reset) begin
      prev_v[0] = bus_a.valid; prev_fe[0] = bus_a.frame_err; prev_sc[0] = bus_a.scancode;
      prev_b[0] = bus_a.is_break; prev_e[0] = bus_a.is_ext;
      prev_v[1] = bus_b.valid; prev_fe[1] = bus_b.frame_err; prev_sc[1] = bus_b.scancode;
      prev_b[1] = bus_b.is_break; prev_e[1] = bus_b.is_ext;
    end else begin
      check_out(0, bus_a.valid, bus_a.frame_err, bus_a.scancode, bus_a.is_break, bus_a.is_ext);
      check_out(1, bus_b.valid, bus_b.frame_err, bus_b.scancode, bus_b.is_break, bus_b.is_ext);
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(posedge clk_in);
    #1 ps2_clock = 1'b0;
    last_fall_cyc = cyc;
    repeat (H) @(posedge clk_in);
    #1 ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    model_frame(b, p, s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(s);
    ps2_data = 1'b1;
    repeat (2 * H) @(posedge clk_in);
    #1;
    $display("frame %h par=%0d stop=%0d  a:%h/%0d/%0d b:%h/%0d/%0d", b, p, s,
             bus_a.scancode, bus_a.is_break, bus_a.is_ext,
             bus_b.scancode, bus_b.is_break, bus_b.is_ext);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic drain(input string name);
    note(name, 0, q0.size() == 0, q0.size(), 0);
    note(name, 1, q1.size() == 0, q1.size(), 0);
  endtask

  task automatic chk_out(input string name, input logic [7:0] sc, input logic b, input logic e);
    note(name, 0, {bus_a.scancode, bus_a.is_break, bus_a.is_ext} == {sc, b, e},
         int'({bus_a.scancode, bus_a.is_break, bus_a.is_ext}), int'({sc, b, e}));
    note(name, 1, {bus_b.scancode, bus_b.is_break, bus_b.is_ext} == {sc, b, e},
         int'({bus_b.scancode, bus_b.is_break, bus_b.is_ext}), int'({sc, b, e}));
  endtask

  task automatic chk_reset(input string name);
    note(name, 0, {bus_a.scancode, bus_a.valid, bus_a.is_break, bus_a.is_ext, bus_a.frame_err} == 12'h0,
         int'({bus_a.scancode, bus_a.valid, bus_a.is_break, bus_a.is_ext, bus_a.frame_err}), 0);
    note(name, 1, {bus_b.scancode, bus_b.valid, bus_b.is_break, bus_b.is_ext, bus_b.frame_err} == 12'h0,
         int'({bus_b.scancode, bus_b.valid, bus_b.is_break, bus_b.is_ext, bus_b.frame_err}), 0);
  endtask

  initial begin
    int nv0, nv1, ne0, ne1, budget;
    for (int i = 0; i < 2; i++) begin
      brk_pend[i] = 1'b0; ext_pend[i] = 1'b0;
      n_valid[i] = 0; n_err[i] = 0; err_cyc[i] = 0;
    end

    reset = 1'b1;
    repeat (5) @(posedge clk_in);
    #1 chk_reset("reset_outputs");
    reset = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;

    good(8'h1C);
    chk_out("byte_1c", 8'h1C, 1'b0, 1'b0);
    note("no_err_1c", 0, n_err[0] == 0, n_err[0], 0);
    drain("drain_1c");

    nv0 = n_valid[0]; nv1 = n_valid[1];
    good(8'hF0);
    good(8'h1C);
    note("break_pair_a", 0, bus_a.is_break == 1'b1, int'(bus_a.is_break), 1);
    good(8'h1C);
    chk_out("after_break", 8'h1C, 1'b0, 1'b0);
    note("break_cnt", 0, n_valid[0] - nv0 == 3, n_valid[0] - nv0, 3);
    note("break_cnt", 1, n_valid[1] - nv1 == 2, n_valid[1] - nv1, 2);
    drain("drain_break");

    nv1 = n_valid[1];
    good(8'hE0);
    good(8'h75);
    note("ext_75_b", 1, {bus_b.scancode, bus_b.is_break, bus_b.is_ext} == {8'h75, 1'b0, 1'b1},
         int'({bus_b.scancode, bus_b.is_break, bus_b.is_ext}), int'({8'h75, 1'b0, 1'b1}));
    note("ext_cnt_b", 1, n_valid[1] - nv1 == 1, n_valid[1] - nv1, 1);
    drain("drain_ext");

    good(8'hE0);
    good(8'hF0);
    note("f0_ext_a", 0, {bus_a.scancode, bus_a.is_break, bus_a.is_ext} == {8'hF0, 1'b0, 1'b1},
         int'({bus_a.scancode, bus_a.is_break, bus_a.is_ext}), int'({8'hF0, 1'b0, 1'b1}));
    good(8'h7C);
    chk_out("ext_break_7c", 8'h7C, 1'b1, 1'b1);
    drain("drain_ext_break");

    ne0 = n_err[0];
    good(8'hF0);
    send_frame(8'h5A, 1'b0, 1'b1);
    note("parity_err", 0, n_err[0] - ne0 == 1, n_err[0] - ne0, 1);
    good(8'h5A);
    chk_out("5a_keeps_break", 8'h5A, 1'b1, 1'b0);
    drain("drain_parity");

    ne1 = n_err[1];
    send_frame(8'h12, ~^8'h12, 1'b0);
    model_err();
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (2 * H) @(posedge clk_in);
    #1 note("stop_start_err", 1, n_err[1] - ne1 == 2, n_err[1] - ne1, 2);
    drain("drain_stop_start");

    model_err();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ne0 = n_err[0];
    budget = 0;
    while (n_err[0] == ne0 && budget < 3 * TO) begin
      @(posedge clk_in);
      budget++;
    end
    #1;
    note("timeout_seen", 0, n_err[0] != ne0, n_err[0] - ne0, 1);
    note("timeout_delay", 0, err_cyc[0] - last_fall_cyc == TO + FILT + 3,
         err_cyc[0] - last_fall_cyc, TO + FILT + 3);
    repeat (50) @(posedge clk_in);
    #1;
    good(8'h45);
    chk_out("after_timeout", 8'h45, 1'b0, 1'b0);
    drain("drain_timeout");

    nv0 = n_valid[0]; ne0 = n_err[0];
    ps2_clock = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 ps2_clock = 1'b1;
    repeat (30) @(posedge clk_in);
    #1 ps2_clock = 1'b0;
    repeat (FILT - 1) @(posedge clk_in);
    #1 ps2_clock = 1'b1;
    repeat (30) @(posedge clk_in);
    #1;
    note("glitch_events", 0, n_valid[0] == nv0 && n_err[0] == ne0,
         (n_valid[0] - nv0) + (n_err[0] - ne0), 0);
    chk_out("glitch_hold", 8'h45, 1'b0, 1'b0);

    good(8'hE0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      brk_pend[i] = 1'b0;
      ext_pend[i] = 1'b0;
    end
    repeat (3) @(posedge clk_in);
    #1 chk_reset("midframe_reset");
    reset = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    good(8'h29);
    chk_out("after_reset_29", 8'h29, 1'b0, 1'b0);
    drain("drain_final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
